// File: rtl/yuv_write_scheduler.sv
// yuv_write_scheduler
//   Buffers incoming YUV pixels in a small FIFO and turns each one into byte
//   writes on an Avalon-MM style master into a planar 4:2:0 frame buffer:
//   a Y byte for every pixel, plus a U byte (even row, even col) or a
//   V byte (even row, odd col).
//
//   Ports
//     clock, resetn            single clock, asynchronous active-low reset
//     pix_valid / pix_ready    pixel handshake (pix_ready = FIFO not full)
//     pix_y, pix_u, pix_v      sample bytes
//     pix_row, pix_col         pixel coordinates
//     frame_start              pulse: clears frame_done / range_err
//     avm_address, avm_writedata, avm_write, avm_waitrequest
//                              byte-wide write master
//     busy                     FIFO non-empty or a write sequence in progress
//     frame_done               sticky: last pixel of the frame written
//     range_err                sticky: an out-of-range pixel was dropped
//     write_count              accepted-write counter, present only when
//                              YUV_SCHED_WRITE_COUNT_EN is defined
//
//   State   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no write outstanding, FIFO empty
//   WR_Y    | Y byte of the FIFO head on the bus
//   WR_U    | U byte of the FIFO head on the bus
//   WR_V    | V byte of the FIFO head on the bus
module yuv_write_scheduler #(
    parameter int WIDTH      = 3264,
    parameter int HEIGHT     = 2448,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_y,
    input  logic [7:0]  pix_u,
    input  logic [7:0]  pix_v,
    input  logic [11:0] pix_row,
    input  logic [11:0] pix_col,
    input  logic        frame_start,
    output logic [26:0] avm_address,
    output logic [7:0]  avm_writedata,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        frame_done,
    output logic        range_err
`ifdef YUV_SCHED_WRITE_COUNT_EN
    ,
    output logic [31:0] write_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR_Y = 2'd1;
    localparam logic [1:0] WR_U = 2'd2;
    localparam logic [1:0] WR_V = 2'd3;

    localparam logic [26:0] W27      = 27'(WIDTH);
    localparam logic [26:0] HALF_W   = 27'(WIDTH / 2);
    localparam logic [26:0] U_BASE   = 27'(WIDTH * HEIGHT);
    localparam logic [26:0] V_BASE   = 27'((WIDTH * HEIGHT * 5) / 4);
    localparam logic [11:0] LAST_ROW = 12'(HEIGHT - 1);
    localparam logic [11:0] LAST_COL = 12'(WIDTH - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    typedef struct packed {
        logic [11:0] row;
        logic [11:0] col;
        logic [7:0]  y;
        logic [7:0]  u;
        logic [7:0]  v;
    } pix_t;

    pix_t           mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  nxt_ptr;
    logic [AW:0]    count;
    logic [1:0]     state;

    pix_t           head;
    logic [11:0]    nxt_row;
    logic [11:0]    nxt_col;
    logic [7:0]     nxt_y;
    logic           in_range;
    logic           push;
    logic           store;
    logic           accept;
    logic           pop;
    logic           head_last;

    function automatic logic [26:0] y_addr(input logic [11:0] r, input logic [11:0] c);
        return 27'(r) * W27 + 27'(c);
    endfunction

    // Chroma planes are subsampled 2x2, so both U and V share this offset.
    function automatic logic [26:0] uv_off(input logic [11:0] r, input logic [11:0] c);
        return 27'(r >> 1) * HALF_W + 27'(c >> 1);
    endfunction

    assign pix_ready = (count != FULL_CNT);
    assign busy      = (count != '0) || (state != IDLE);

    assign in_range  = ({20'd0, pix_row} < 32'(HEIGHT)) && ({20'd0, pix_col} < 32'(WIDTH));
    assign push      = pix_valid && pix_ready;
    assign store     = push && in_range;
    assign accept    = avm_write && !avm_waitrequest;

    assign head      = mem[rd_ptr];
    assign nxt_ptr   = rd_ptr + AW'(1);
    assign nxt_row   = mem[nxt_ptr].row;
    assign nxt_col   = mem[nxt_ptr].col;
    assign nxt_y     = mem[nxt_ptr].y;
    assign head_last = (head.row == LAST_ROW) && (head.col == LAST_COL);

    // Odd rows carry no chroma, so their Y write is also their last write.
    assign pop = accept && ((state == WR_U) || (state == WR_V) ||
                            ((state == WR_Y) && head.row[0]));

    always_ff @(posedge clock) begin
        if (store) begin
            mem[wr_ptr] <= '{row: pix_row, col: pix_col, y: pix_y, u: pix_u, v: pix_v};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= nxt_ptr;
            case ({store, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state         <= WR_Y;
                        avm_write     <= 1'b1;
                        avm_address   <= y_addr(head.row, head.col);
                        avm_writedata <= head.y;
                    end
                end
                WR_Y: begin
                    if (accept && !head.row[0]) begin
                        avm_address <= (head.col[0] ? V_BASE : U_BASE) + uv_off(head.row, head.col);
                        if (head.col[0]) begin
                            state         <= WR_V;
                            avm_writedata <= head.v;
                        end else begin
                            state         <= WR_U;
                            avm_writedata <= head.u;
                        end
                    end
                end
                default: ;
            endcase

            // Advance straight to the next queued pixel so the bus sees no gap.
            // A pixel pushed in this same cycle is not yet visible, so it is
            // picked up from IDLE one cycle later.
            if (pop) begin
                if (count > ONE_CNT) begin
                    state         <= WR_Y;
                    avm_address   <= y_addr(nxt_row, nxt_col);
                    avm_writedata <= nxt_y;
                end else begin
                    state     <= IDLE;
                    avm_write <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_done <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            if (frame_start) begin
                frame_done <= 1'b0;
                range_err  <= 1'b0;
            end else begin
                if (pop && head_last)    frame_done <= 1'b1;
                if (push && !in_range)   range_err  <= 1'b1;
            end
        end
    end

`ifdef YUV_SCHED_WRITE_COUNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            write_count <= '0;
        end else if (frame_start) begin
            write_count <= '0;
        end else if (accept) begin
            write_count <= write_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_yuv_write_scheduler.sv
module tb_yuv_write_scheduler;

    localparam int WIDTH  = 3264;
    localparam int HEIGHT = 2448;
    localparam int U_BASE = WIDTH * HEIGHT;
    localparam int V_BASE = (WIDTH * HEIGHT * 5) / 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_y = '0, pix_u = '0, pix_v = '0;
    logic [11:0] pix_row = '0, pix_col = '0;
    logic        frame_start = 1'b0;
    logic [26:0] avm_address;
    logic [7:0]  avm_writedata;
    logic        avm_write;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        range_err;
`ifdef YUV_SCHED_WRITE_COUNT_EN
    logic [31:0] write_count;
`endif

    yuv_write_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(4)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_y          (pix_y),
        .pix_u          (pix_u),
        .pix_v          (pix_v),
        .pix_row        (pix_row),
        .pix_col        (pix_col),
        .frame_start    (frame_start),
        .avm_address    (avm_address),
        .avm_writedata  (avm_writedata),
        .avm_write      (avm_write),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .frame_done     (frame_done),
        .range_err      (range_err)
`ifdef YUV_SCHED_WRITE_COUNT_EN
        ,
        .write_count    (write_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pushes   = 0;
    int hi_cycles = 0;
    int acc_count = 0;
    int exp_wc   = 0;
    bit rand_wr  = 1'b0;
    bit wr_force = 1'b0;
    bit prev_stall = 1'b0;
    logic [26:0] held_addr;
    logic [7:0]  held_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // Reference: each in-range pixel expands to its list of (address, byte) writes.
    task automatic model_push(input int r, input int c, input logic [7:0] y, input logic [7:0] u,
                              input logic [7:0] v);
        int cb;
        if (r >= HEIGHT || c >= WIDTH) return;
        sb_q.push_back('{addr: 32'(r * WIDTH + c), data: {24'd0, y}});
        if (r % 2 == 0) begin
            cb = (r / 2) * (WIDTH / 2) + (c / 2);
            if (c % 2 == 0) sb_q.push_back('{addr: 32'(U_BASE + cb), data: {24'd0, u}});
            else            sb_q.push_back('{addr: 32'(V_BASE + cb), data: {24'd0, v}});
        end
    endtask

    always @(posedge clock) begin
        #2;
        avm_waitrequest = rand_wr ? ($urandom_range(0, 2) == 0) : wr_force;
    end

    // Monitor: samples mid-cycle, values are what the next rising edge acts on.
    always @(negedge clock) begin
        wr_t e;
        if (!resetn) begin
            prev_stall = 1'b0;
            sb_q.delete();
            exp_wc = 0;
        end else begin
            if (pix_valid && pix_ready) begin
                model_push(int'(pix_row), int'(pix_col), pix_y, pix_u, pix_v);
                pushes++;
            end
            if (avm_write) begin
                hi_cycles++;
                if (prev_stall) begin
                    check("stall_addr_stable", 32'(avm_address), 32'(held_addr));
                    check("stall_data_stable", 32'(avm_writedata), 32'(held_data));
                end
                if (!avm_waitrequest) begin
                    acc_count++;
                    exp_wc++;
                    check("write_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("wr_addr", 32'(avm_address), e.addr);
                        check("wr_data", 32'(avm_writedata), e.data);
                    end
                end
            end
            if (frame_start) exp_wc = 0;
            prev_stall = avm_write && avm_waitrequest;
            held_addr  = avm_address;
            held_data  = avm_writedata;
        end
    end

    task automatic send_pixel(input logic [11:0] r, input logic [11:0] c, input logic [7:0] y,
                              input logic [7:0] u, input logic [7:0] v);
        int t = 0;
        bit done = 1'b0;
        @(posedge clock); #1;
        pix_row = r; pix_col = c; pix_y = y; pix_u = u; pix_v = v;
        pix_valid = 1'b1;
        while (!done && t < 50) begin
            @(negedge clock);
            if (pix_ready) done = 1'b1;
            else t++;
        end
        check("push_within_budget", 32'(done), 32'd1);
        @(posedge clock); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int t = 0;
        while ((busy || sb_q.size() != 0) && t < max_cycles) begin
            @(negedge clock);
            t++;
        end
        check("drain_within_budget", 32'(!busy && sb_q.size() == 0), 32'd1);
    endtask

    task automatic wait_write(input int max_cycles);
        int t = 0;
        @(negedge clock);
        while (!avm_write && t < max_cycles) begin
            @(negedge clock);
            t++;
        end
        check("write_within_budget", 32'(avm_write), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, a0, p0, k, run;

        // Reset values
        #12;
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_address", 32'(avm_address), 32'd0);
        check("rst_avm_writedata", 32'(avm_writedata), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd1);
        @(posedge clock); #1;
        resetn = 1'b1;

        // (0,0): Y then U; avm_write rises the edge after the push
        wr_force = 1'b0;
        send_pixel(12'd0, 12'd0, 8'h10, 8'h20, 8'h30);
        check("write_low_at_push", 32'(avm_write), 32'd0);
        check("busy_after_push", 32'(busy), 32'd1);
        @(posedge clock); #1;
        check("write_high_next_edge", 32'(avm_write), 32'd1);
        wait_idle(20);

        // (0,1): Y then V
        send_pixel(12'd0, 12'd1, 8'h11, 8'h21, 8'h31);
        wait_idle(20);

        // (1,0): single Y write held off for 3 cycles
        wr_force = 1'b1;
        h0 = hi_cycles; a0 = acc_count;
        send_pixel(12'd1, 12'd0, 8'h61, 8'h62, 8'h63);
        wait_write(10);
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        wr_force = 1'b0;
        wait_idle(20);
        check("stall_high_cycles", 32'(hi_cycles - h0), 32'd4);
        check("stall_acceptances", 32'(acc_count - a0), 32'd1);

        // Six back-to-back pixels against a stalled slave
        wr_force = 1'b1;
        p0 = pushes; k = 0;
        @(posedge clock); #1;
        pix_row = 12'd3; pix_col = 12'd5; pix_y = 8'h40; pix_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clock);
            if (pix_ready) begin
                @(posedge clock); #1;
                k++;
                if (k < 6) begin
                    pix_col = 12'(5 + k);
                    pix_y   = 8'(8'h40 + k);
                end else begin
                    pix_valid = 1'b0;
                end
            end else begin
                @(posedge clock); #1;
            end
        end
        check("full_push_count", 32'(pushes - p0), 32'd4);
        check("full_pix_ready", 32'(pix_ready), 32'd0);
        pix_valid = 1'b0;
        wr_force = 1'b0;
        run = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (avm_write) run++;
        end
        check("drain_no_gaps", 32'(run), 32'd4);
        @(negedge clock);
        check("drain_write_low", 32'(avm_write), 32'd0);
        check("drain_not_busy", 32'(busy), 32'd0);

        // Last pixel of the frame, frame_start, out-of-range pixel
        send_pixel(12'd2447, 12'd3263, 8'hAA, 8'hAB, 8'hAC);
        check("fd_low_at_push", 32'(frame_done), 32'd0);
        @(posedge clock); #1;
        check("fd_low_while_writing", 32'(frame_done), 32'd0);
        @(posedge clock); #1;
        check("fd_set_on_accept", 32'(frame_done), 32'd1);
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        check("fd_cleared", 32'(frame_done), 32'd0);
        h0 = hi_cycles;
        send_pixel(12'd0, 12'd3264, 8'h01, 8'h02, 8'h03);
        check("oor_range_err", 32'(range_err), 32'd1);
        repeat (5) @(negedge clock);
        check("oor_no_write", 32'(hi_cycles - h0), 32'd0);
        check("oor_not_busy", 32'(busy), 32'd0);
        // frame_start wins over a same-cycle out-of-range push
        @(posedge clock); #1;
        pix_row = 12'd3000; pix_col = 12'd0; pix_valid = 1'b1; frame_start = 1'b1;
        @(posedge clock); #1;
        pix_valid = 1'b0; frame_start = 1'b0;
        check("start_priority_range_err", 32'(range_err), 32'd0);

        // Randomized traffic against a randomly stalling slave
        rand_wr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [11:0] r, c;
            r = 12'($urandom_range(0, HEIGHT - 1));
            c = 12'($urandom_range(0, WIDTH - 1));
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0) r = 12'($urandom_range(HEIGHT, 4095));
                else                           c = 12'($urandom_range(WIDTH, 4095));
            end
            repeat ($urandom_range(0, 2)) @(posedge clock);
            send_pixel(r, c, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        rand_wr = 1'b0;
        wait_idle(3000);

`ifdef YUV_SCHED_WRITE_COUNT_EN
        check("write_count", write_count, 32'(exp_wc));
`endif

        // Reset while a write is stalled: abandoned, not reissued
        wr_force = 1'b1;
        send_pixel(12'd5, 12'd5, 8'h77, 8'h78, 8'h79);
        wait_write(10);
        @(posedge clock); #3;
        resetn = 1'b0;
        #1;
        check("rst_mid_avm_write", 32'(avm_write), 32'd0);
        check("rst_mid_avm_address", 32'(avm_address), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_pix_ready", 32'(pix_ready), 32'd1);
        @(posedge clock); #1;
        resetn = 1'b1;
        wr_force = 1'b0;
        h0 = hi_cycles;
        repeat (6) @(negedge clock);
        check("no_reissue_after_reset", 32'(hi_cycles - h0), 32'd0);
`ifdef YUV_SCHED_WRITE_COUNT_EN
        check("write_count_after_reset", write_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
